// File: rtl/shared_reg_pkg.sv
// Shared-register arbiter package: FSM state type and index-width helper.
package shared_reg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = (n <= 2) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Round-robin winner selection: searches upward from last_owner+1 with wrap.
module rr_picker
    import shared_reg_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    win_idx
);

    logic        found;
    int unsigned cand;

    // First requesting slot after last_owner, in circular order.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(last_owner) + off) % N_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                win_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// Optional hold-limit preemption is enabled with `define SHARED_REG_HOLD_LIMIT_EN.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       wr_en,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   busy
);

    localparam int unsigned IW = idx_w(N_REQ);

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IW-1:0]    owner_idx, owner_idx_n;
    logic [IW-1:0]    last_owner, last_owner_n;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             owner_req;
    logic             do_write;

`ifdef SHARED_REG_HOLD_LIMIT_EN
    localparam int unsigned HW = idx_w(MAX_HOLD);
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          others_req;
`else
    logic [31:0] unused_max_hold;
    assign unused_max_hold = 32'(MAX_HOLD);
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_onehot),
        .win_idx    (pick_idx)
    );

    assign owner_req = |(gnt & req);
    assign do_write  = (state == OWN) && (|(gnt & req & wr_en));
    assign busy      = (state != IDLE);

`ifdef SHARED_REG_HOLD_LIMIT_EN
    assign others_req = |(req & ~gnt);
`endif

    // Next-state, next-grant and ownership bookkeeping.
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        owner_idx_n  = owner_idx;
        last_owner_n = last_owner;
`ifdef SHARED_REG_HOLD_LIMIT_EN
        hold_cnt_n   = hold_cnt;
`endif
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    state_n     = OWN;
                    gnt_n       = pick_onehot;
                    owner_idx_n = pick_idx;
`ifdef SHARED_REG_HOLD_LIMIT_EN
                    hold_cnt_n  = '0;
`endif
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_n      = RELEASE;
                    gnt_n        = '0;
                    last_owner_n = owner_idx;
                end
`ifdef SHARED_REG_HOLD_LIMIT_EN
                else if ((hold_cnt == HW'(MAX_HOLD - 1)) && others_req) begin
                    state_n      = RELEASE;
                    gnt_n        = '0;
                    last_owner_n = owner_idx;
                end
                else if (hold_cnt != HW'(MAX_HOLD - 1)) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
`endif
            end
            RELEASE: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // FSM, grant and ownership registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            owner_idx  <= '0;
            last_owner <= IW'(N_REQ - 1);
`ifdef SHARED_REG_HOLD_LIMIT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner_idx  <= owner_idx_n;
            last_owner <= last_owner_n;
`ifdef SHARED_REG_HOLD_LIMIT_EN
            hold_cnt   <= hold_cnt_n;
`endif
        end
    end

    // Shared register: loads only the current owner's slice on a qualified write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (do_write) begin
            q <= wdata[owner_idx*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  wr_en;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shared_reg_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wr_en (wr_en),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'($urandom);
        wr_en = 4'($urandom);
        wdata = $urandom;

        // Reset with random inputs.
        repeat (3) begin
            tick();
            req   = 4'($urandom);
            wr_en = 4'($urandom);
            wdata = $urandom;
        end
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_q", 32'(q), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);

        req   = 4'b0000;
        wr_en = 4'b0000;
        wdata = 32'h0;
        rst_n = 1'b1;
        tick();
        req = 4'b0010;
        tick();
        check_val("first_gnt", 32'(gnt), 32'h2);
        check_val("first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        check_val("drop_gnt", 32'(gnt), 32'h0);
        check_val("release_busy", 32'(busy), 32'h1);
        tick();
        check_val("idle_busy", 32'(busy), 32'h0);

        // Fresh reset, then all four request: order 0,1,2,3,0 with 2 dead cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("rr_gnt%0d", i), 32'(gnt), 32'h1 << (i % 4));
            req = 4'b1111 & ~(4'b0001 << (i % 4));
            tick();
            check_val($sformatf("rr_gap_a%0d", i), 32'(gnt), 32'h0);
            req = 4'b1111;
            tick();
            check_val($sformatf("rr_gap_b%0d", i), 32'(gnt), 32'h0);
            tick();
        end
        // Requester 1 now owns; release it.
        check_val("rr_after", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        tick();

        // Write qualification with requester 2 owning.
        req = 4'b0100;
        tick();
        check_val("wr_gnt", 32'(gnt), 32'h4);
        wr_en = 4'b0100;
        wdata = 32'h00A5_0000;
        tick();
        check_val("wr_own", 32'(q), 32'hA5);
        wr_en = 4'b0001;
        wdata = 32'h0011_00FF;
        tick();
        check_val("wr_nonowner", 32'(q), 32'hA5);
        wr_en = 4'b0100;
        wdata = 32'h0077_0000;
        req   = 4'b0000;
        tick();
        check_val("wr_drop_q", 32'(q), 32'hA5);
        check_val("wr_drop_gnt", 32'(gnt), 32'h0);
        wr_en = 4'b0000;
        tick();

        // Hold limit: req0 and req1 both high, last owner is 2 so 0 wins.
        req = 4'b0011;
        tick();
        check_val("hold_gnt0", 32'(gnt), 32'h1);
`ifdef SHARED_REG_HOLD_LIMIT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("hold_keep%0d", i), 32'(gnt), 32'h1);
        end
        tick();
        check_val("hold_release", 32'(gnt), 32'h0);
        tick();
        check_val("hold_idle", 32'(gnt), 32'h0);
        tick();
        check_val("hold_gnt1", 32'(gnt), 32'h2);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val($sformatf("nohold_keep%0d", i), 32'(gnt), 32'h1);
        end
        req = 4'b0010;
        tick();
        check_val("nohold_release", 32'(gnt), 32'h0);
        tick();
        check_val("nohold_idle", 32'(gnt), 32'h0);
        tick();
        check_val("nohold_gnt1", 32'(gnt), 32'h2);
`endif
        req = 4'b0000;
        tick();
        tick();

        // Sole owner: requester 3 keeps the register indefinitely.
        req = 4'b1000;
        tick();
        for (int i = 0; i < 20; i++) begin
            check_val($sformatf("sole_gnt%0d", i), 32'(gnt), 32'h8);
            tick();
        end
        check_val("sole_busy", 32'(busy), 32'h1);
        wr_en = 4'b1000;
        wdata = 32'h3C00_0000;
        tick();
        check_val("sole_wr", 32'(q), 32'h3C);
        wr_en = 4'b0000;

        // Asynchronous reset between edges clears everything immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_gnt", 32'(gnt), 32'h0);
        check_val("async_q", 32'(q), 32'h0);
        check_val("async_busy", 32'(busy), 32'h0);
        #1;
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        check_val("post_rst_gnt", 32'(gnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among N_REQ requesters. Each requester raises a request, receives a one-hot grant, and may load the shared register while it owns it. A dead cycle separates ownership changes. The block sits between the class datapath's client units and the common storage flip-flops it sequences.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- WIDTH, default 8: shared register width.
- MAX_HOLD, default 4: maximum consecutive owned cycles while others wait (only with the hold-limit feature).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester ownership request, level.
- wr_en  in  N_REQ  per-requester write strobe.
- wdata  in  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, registered; all-zero when unowned.
- q  out  WIDTH  shared register contents, registered.
- busy  out  1  high in OWN and RELEASE states.

## Operation
- States: IDLE, OWN, RELEASE.
- IDLE: gnt=0. If any req bit is high, pick a winner by round-robin, starting from (last_owner+1) mod N_REQ and searching upward with wrap-around. Go to OWN with gnt set to the winner and hold_cnt=0.
- OWN: q loads the owner's wdata slice on an edge where gnt[i] & req[i] & wr_en[i] are all high. wr_en from non-owners is always ignored. hold_cnt increments each OWN cycle and saturates at MAX_HOLD-1.
- OWN -> RELEASE when the owner's req is low at the edge. With the hold-limit feature, also when hold_cnt==MAX_HOLD-1 and any other req bit is high. On this transition, last_owner is set to the owner.
- RELEASE: lasts exactly one cycle with gnt=0 and no writes. Next state is IDLE, where arbitration happens on the following edge.
- If only the owner requests, ownership continues regardless of hold_cnt.
- last_owner resets to N_REQ-1, so requester 0 wins the first arbitration when several request at once.
- Reset values: gnt=0, q=0, busy=0, state=IDLE, hold_cnt=0, last_owner=N_REQ-1.
- Asserting reset mid-ownership clears all of the above immediately. Any in-flight write is lost.

## Timing
- Request to grant: req sampled high at edge k with state IDLE gives gnt high after edge k. Worst case from the start of a release is 2 cycles (RELEASE, then IDLE).
- Write latency: q reflects wdata after the same edge at which the write is qualified.
- The owner's req dropping at edge k gives gnt=0 after edge k. Any wr_en at edge k is ignored, because req is low.
- Handover: the minimum gap between two different grants is 2 cycles (RELEASE + IDLE).
- The owner's req and another requester's req changing on the same edge are each evaluated using that edge's sampled values.

## Configuration
- SHARED_REG_HOLD_LIMIT_EN defined: MAX_HOLD preemption is active as described above.
- SHARED_REG_HOLD_LIMIT_EN undefined: there is no preemption and no hold_cnt. The owner keeps the register until it drops req. The MAX_HOLD parameter is accepted and ignored.

## Structure
- Package shared_reg_pkg contains:
  - the state enum typedef (IDLE, OWN, RELEASE);
  - an index-width constant function, clog2 of N_REQ with a minimum of 1.
- Sub-module rr_picker: combinational; takes req and last_owner and returns the one-hot winner and its index.
- Top level: FSM, hold counter, last_owner register, and the q flip-flops.

## Test plan
- Reset: hold rst_n=0 with random inputs -> gnt=0, q=0, busy=0. Deassert rst_n, set req=4'b0010 -> gnt=4'b0010 after one edge.
- Simultaneous requests: req=4'b1111 from IDLE after reset -> grant order 0,1,2,3,0. Each requester drops req after 1 owned cycle, and each grant is separated by 2 zero-grant cycles.
- Write qualification: owner 2 writes wdata slice 8'hA5 with wr_en=1 -> q=8'hA5. A non-owner's wr_en with 8'hFF -> q stays 8'hA5.
- Hold limit (macro defined, MAX_HOLD=4): req0 held high with req1 high -> gnt0 for 4 cycles, RELEASE, IDLE, then gnt1. With the macro undefined -> gnt0 for the entire time req0 is held.
- Sole owner: only req3 high for 20 cycles with the macro defined -> gnt3 continuous, no RELEASE.
- Mid-operation reset: during OWN with q=8'h3C, pulse rst_n low asynchronously between edges -> gnt=0 and q=0 immediately. After release, with req=4'b1111 -> requester 0 is granted first.
